// File: rtl/qe_m_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qe_m_pkg
// Purpose  : Shared definitions for the QE_M driver slice: default operand
//            and result widths, mode encodings, command bundle type and the
//            helper that decides whether a command will produce a result.
// Revision : 1.0 - initial release
// ============================================================================
package qe_m_pkg;

  localparam int QE_DATA_W = 8;
  localparam int QE_RES_W  = 16;

  localparam logic QE_MODE_QUAD = 1'b0;  // a*x*x + b*x + c
  localparam logic QE_MODE_MAC  = 1'b1;  // accumulate a*x over a burst

  // One operand command at the default widths.
  typedef struct packed {
    logic                 mode;
    logic                 last;
    logic [QE_DATA_W-1:0] a;
    logic [QE_DATA_W-1:0] b;
    logic [QE_DATA_W-1:0] c;
    logic [QE_DATA_W-1:0] x;
  } qe_cmd_t;

  // A quadratic command yields a result unless it arrives inside an open
  // burst (then it is dropped). A MAC element yields a result only when it
  // closes its burst, either explicitly or by hitting the length limit.
  function automatic logic qe_res_producing(input logic mode,
                                            input logic last,
                                            input logic burst_open,
                                            input logic at_max);
    return (mode == QE_MODE_QUAD) ? !burst_open : (last | at_max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qe_m_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : qe_m_driver_if
// Purpose  : Bundles the command handshake, the QE_M input/output signals and
//            the result handshake of the QE_M driver.
//   master : driver view (accepts commands, drives QE_M, sources results)
//   slave  : environment view (issues commands, models QE_M, sinks results)
// Revision : 1.0 - initial release
// ============================================================================
interface qe_m_driver_if
  import qe_m_pkg::*;
#(
  parameter int DATA_W = QE_DATA_W,
  parameter int RES_W  = QE_RES_W
);
  // command handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic              cmd_last;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [DATA_W-1:0] cmd_c;
  logic [DATA_W-1:0] cmd_x;
  // QE_M inputs
  logic              qe_valid_in;
  logic              qe_mode;
  logic              qe_last_input;
  logic [DATA_W-1:0] qe_in_a;
  logic [DATA_W-1:0] qe_in_b;
  logic [DATA_W-1:0] qe_in_c;
  logic [DATA_W-1:0] qe_in_x;
  // QE_M outputs
  logic              qe_valid_out;
  logic [RES_W-1:0]  qe_result;
  // result handshake
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;

  modport master (
    input  cmd_valid, cmd_mode, cmd_last, cmd_a, cmd_b, cmd_c, cmd_x,
    input  qe_valid_out, qe_result, res_ready,
    output cmd_ready,
    output qe_valid_in, qe_mode, qe_last_input,
    output qe_in_a, qe_in_b, qe_in_c, qe_in_x,
    output res_valid, res_data
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_last, cmd_a, cmd_b, cmd_c, cmd_x,
    output qe_valid_out, qe_result, res_ready,
    input  cmd_ready,
    input  qe_valid_in, qe_mode, qe_last_input,
    input  qe_in_a, qe_in_b, qe_in_c, qe_in_x,
    input  res_valid, res_data
  );
endinterface
`default_nettype wire

// File: rtl/qe_m_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qe_m_res_fifo
// Purpose  : Synchronous result FIFO. A push while full is accepted only when
//            a pop happens in the same cycle; otherwise it is ignored.
// Ports    : clk, rst (sync, active-high), i_push/i_data, i_pop,
//            o_data (head, valid while !o_empty), o_full, o_empty
// Revision : 1.0 - initial release
// ============================================================================
module qe_m_res_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int c_AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty.
  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_pop  = i_pop & !o_empty;
  assign w_do_push = i_push & (!o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/qe_m_driver.sv
`default_nettype none
// ============================================================================
// Module   : qe_m_driver
// Purpose  : Front-end transmitter for the QE_M quadratic/MAC unit. Accepts
//            operand commands, issues them to QE_M one cycle later, frames
//            MAC bursts with a length limit and buffers results. Credits
//            guarantee room for every result, since QE_M cannot be stalled.
// Ports    : clk, reset (sync, active-high)
//            bus      - command, QE_M and result signals (master view)
//            err_mode - sticky: quadratic command inside an open burst
//            err_ovf  - sticky: QE_M result arrived with the FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module qe_m_driver
  import qe_m_pkg::*;
#(
  parameter int DATA_W    = QE_DATA_W,
  parameter int RES_W     = QE_RES_W,
  parameter int RES_DEPTH = 4,
  parameter int MAX_BURST = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  qe_m_driver_if.master   bus,
  output logic            err_mode,
  output logic            err_ovf
);
  localparam int c_CRED_W  = $clog2(RES_DEPTH + 1);
  localparam int c_BURST_W = $clog2(MAX_BURST);

  logic [c_CRED_W-1:0]  r_credits;
  logic [c_BURST_W-1:0] r_burst_cnt;
  logic                 r_burst_open;

  logic w_at_max;
  logic w_res_prod;
  logic w_mode_err;
  logic w_accept;
  logic w_issue;
  logic w_take;
  logic w_pop;
  logic w_full;
  logic w_empty;

  assign w_at_max   = (r_burst_cnt == c_BURST_W'(MAX_BURST - 1));
  assign w_res_prod = qe_res_producing(bus.cmd_mode, bus.cmd_last,
                                       r_burst_open, w_at_max);
  assign w_mode_err = (bus.cmd_mode == QE_MODE_QUAD) & r_burst_open;

  // Depends only on state and the command's mode/last, so a consumer that
  // waits for ready before raising valid cannot form a loop.
  assign bus.cmd_ready = !reset & ((r_credits != '0) | !w_res_prod);

  assign w_accept = bus.cmd_valid & bus.cmd_ready;
  assign w_issue  = w_accept & !w_mode_err;
  assign w_take   = w_accept & w_res_prod;
  assign w_pop    = bus.res_ready & !w_empty;

  assign bus.res_valid = !w_empty;

  // Credit counter and burst framing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits    <= c_CRED_W'(RES_DEPTH);
      r_burst_cnt  <= '0;
      r_burst_open <= 1'b0;
    end else begin
      case ({w_take, w_pop})
        2'b10:   r_credits <= r_credits - c_CRED_W'(1);
        2'b01:   r_credits <= r_credits + c_CRED_W'(1);
        default: r_credits <= r_credits;
      endcase
      if (w_accept && bus.cmd_mode == QE_MODE_MAC) begin
        if (w_res_prod) begin
          r_burst_cnt  <= '0;
          r_burst_open <= 1'b0;
        end else begin
          r_burst_cnt  <= r_burst_cnt + c_BURST_W'(1);
          r_burst_open <= 1'b1;
        end
      end
    end
  end

  // QE_M input registers: strobes pulse per issue, data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.qe_valid_in   <= 1'b0;
      bus.qe_last_input <= 1'b0;
      bus.qe_mode       <= 1'b0;
      bus.qe_in_a       <= '0;
      bus.qe_in_b       <= '0;
      bus.qe_in_c       <= '0;
      bus.qe_in_x       <= '0;
    end else begin
      bus.qe_valid_in   <= w_issue;
      bus.qe_last_input <= w_issue & (bus.cmd_mode == QE_MODE_MAC) & w_res_prod;
      if (w_issue) begin
        bus.qe_mode <= bus.cmd_mode;
        bus.qe_in_a <= bus.cmd_a;
        bus.qe_in_b <= bus.cmd_b;
        bus.qe_in_c <= bus.cmd_c;
        bus.qe_in_x <= bus.cmd_x;
      end
    end
  end

  // Sticky error flags. A push on a full FIFO is only lost when no pop
  // frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_mode <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      if (w_accept & w_mode_err)                       err_mode <= 1'b1;
      if (bus.qe_valid_out & w_full & !bus.res_ready)  err_ovf  <= 1'b1;
    end
  end

  qe_m_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (RES_W)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (bus.qe_valid_out),
    .i_data  (bus.qe_result),
    .i_pop   (bus.res_ready),
    .o_data  (bus.res_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire
